// File: rtl/conv_tap_sequencer_pkg.sv
// Shared state encoding and arithmetic helpers for the conv tap sequencer.
// relu() is applied only in builds that define CONV_SEQ_RELU_EN.
package conv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        HOLD
    } seq_state_t;

    // Helpers work on a fixed wide signed carrier so one function serves any W/K.
    localparam int MAX_ACC_W = 128;
    typedef logic signed [MAX_ACC_W-1:0] wide_t;

    function automatic int acc_w(input int w, input int k);
        return 2*w + $clog2(k);
    endfunction

    function automatic wide_t sat_2w(input wide_t v, input int ow);
        wide_t one;
        wide_t hi;
        wide_t lo;
        one = wide_t'(1);
        hi  = (one <<< (ow-1)) - one;
        lo  = ~hi;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic wide_t relu(input wide_t v);
        return (v < 0) ? '0 : v;
    endfunction

endpackage

// File: rtl/conv_tap_sequencer_if.sv
// Upstream tap-bundle and downstream result handshakes of the conv tap sequencer.
// master = producer/consumer side, slave = the sequencer.
interface conv_tap_sequencer_if #(
    parameter int W     = 16,
    parameter int IN_D  = 4,
    parameter int OUT_D = 8,
    parameter int K     = 2
);
    logic                   in_v;
    logic                   in_rdy;
    logic [K*IN_D*W-1:0]    in_taps;
    logic [2*OUT_D*W-1:0]   out;
    logic                   out_v;
    logic                   out_rdy;

    modport master (
        output in_v, in_taps, out_rdy,
        input  in_rdy, out, out_v
    );

    modport slave (
        input  in_v, in_taps, out_rdy,
        output in_rdy, out, out_v
    );
endinterface

// File: rtl/conv_tap_sequencer_col_accumulator.sv
// One output column: widened signed accumulator with saturated result.
// CONV_SEQ_RELU_EN additionally clamps negative saturated results to zero.
module col_accumulator
    import conv_seq_pkg::*;
#(
    parameter int W = 16,
    parameter int K = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            add,
    input  logic [2*W-1:0]  prod,
    output logic [2*W-1:0]  res
);
    localparam int OW    = 2*W;
    localparam int ACC_W = acc_w(W, K);

    logic signed [ACC_W-1:0] acc;
    wide_t                   acc_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= acc + {{(ACC_W-OW){prod[OW-1]}}, prod};
        end
    end

    assign acc_ext = {{(MAX_ACC_W-ACC_W){acc[ACC_W-1]}}, acc};

    always_comb begin
`ifdef CONV_SEQ_RELU_EN
        res = OW'(relu(sat_2w(acc_ext, OW)));
`else
        res = OW'(sat_2w(acc_ext, OW));
`endif
    end

endmodule

// File: rtl/conv_tap_sequencer.sv
// Issues K cached tap rows to a tap-indexed multiply unit and returns the saturated row sum.
// Build option CONV_SEQ_RELU_EN zeroes negative result columns (inside col_accumulator).
//
// state | meaning
// IDLE  | in_rdy high, waiting for a tap bundle
// ISSUE | one tap row per cycle on mm_a/mm_tap with mm_v high
// DRAIN | waiting for the remaining products
// HOLD  | result presented until downstream takes it
module conv_tap_sequencer
    import conv_seq_pkg::*;
#(
    parameter int W     = 16,
    parameter int IN_D  = 4,
    parameter int OUT_D = 8,
    parameter int K     = 2,
    localparam int TW   = $clog2(K)
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_tap_sequencer_if.slave   bus,
    output logic [IN_D*W-1:0]     mm_a,
    output logic [TW-1:0]         mm_tap,
    output logic                  mm_v,
    input  logic [2*OUT_D*W-1:0]  mm_out,
    input  logic                  mm_out_v,
    output logic                  err
);
    localparam int OW    = 2*W;
    localparam int TAP_W = IN_D*W;
    localparam int RW    = $clog2(K+1);

    seq_state_t             state;
    logic [TW-1:0]          iss;
    logic [TW-1:0]          iss_nxt;
    logic [RW-1:0]          rcv;
    logic [TAP_W-1:0]       tap_q [K];
    logic                   acc_clr;
    logic                   acc_add;
    logic [OW-1:0]          col_res [OUT_D];
    logic [2*OUT_D*W-1:0]   out_nxt;

    assign iss_nxt = iss + TW'(1);
    assign acc_clr = (state == IDLE) && bus.in_v;
    // A product counts only while a bundle is outstanding and not yet complete.
    assign acc_add = mm_out_v && ((state == ISSUE) || (state == DRAIN)) && (rcv != RW'(K));

    for (genvar c = 0; c < OUT_D; c++) begin : g_col
        col_accumulator #(.W(W), .K(K)) u_acc (
            .clk  (clk),
            .rst  (rst),
            .clr  (acc_clr),
            .add  (acc_add),
            .prod (mm_out[(OUT_D-1-c)*OW +: OW]),
            .res  (col_res[c])
        );
    end

    always_comb begin
        out_nxt = '0;
        for (int c = 0; c < OUT_D; c++) begin
            out_nxt[(OUT_D-1-c)*OW +: OW] = col_res[c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            iss        <= '0;
            rcv        <= '0;
            bus.in_rdy <= 1'b1;
            bus.out_v  <= 1'b0;
            bus.out    <= '0;
            mm_v       <= 1'b0;
            mm_a       <= '0;
            mm_tap     <= '0;
            err        <= 1'b0;
            for (int t = 0; t < K; t++) begin
                tap_q[t] <= '0;
            end
        end else begin
            if (mm_out_v) begin
                if (acc_add) begin
                    rcv <= rcv + RW'(1);
                end else begin
                    err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.in_v) begin
                        for (int t = 0; t < K; t++) begin
                            tap_q[t] <= bus.in_taps[(K-1-t)*TAP_W +: TAP_W];
                        end
                        iss        <= '0;
                        rcv        <= '0;
                        mm_v       <= 1'b1;
                        mm_a       <= bus.in_taps[(K-1)*TAP_W +: TAP_W];
                        mm_tap     <= '0;
                        bus.in_rdy <= 1'b0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (iss == TW'(K-1)) begin
                        mm_v  <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        iss    <= iss_nxt;
                        mm_a   <= tap_q[iss_nxt];
                        mm_tap <= iss_nxt;
                    end
                end
                DRAIN: begin
                    // rcv is registered, so the last product is already in the accumulators.
                    if (rcv == RW'(K)) begin
                        bus.out   <= out_nxt;
                        bus.out_v <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_rdy) begin
                        bus.out_v  <= 1'b0;
                        bus.in_rdy <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
